// File: rtl/pll_scan_responder.sv
// Behavioural responder for a PLL dynamic-reconfiguration scan chain: shifts the
// serial image in, applies it on configupdate, then emulates a relock sequence.
module pll_scan_responder #(
  parameter int unsigned          CHAIN_LEN     = 144,
  parameter logic [CHAIN_LEN-1:0] INIT_CFG      = '0,
  parameter int unsigned          UPDATE_CYCLES = 4,
  parameter int unsigned          LOCK_CYCLES   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 areset,
  input  logic                 pfdena,
  input  logic                 scanclk,
  input  logic                 scanclkena,
  input  logic                 scandata,
  input  logic                 configupdate,
  output logic                 scandataout,
  output logic                 scandone,
  output logic                 locked,
  output logic [CHAIN_LEN-1:0] active_cfg,
  output logic [7:0]           shift_count
);

  typedef enum logic [1:0] {
    RELOCK = 2'd0,
    IDLE   = 2'd1,
    SHIFT  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  localparam logic [7:0]  UPD_LAST  = 8'(UPDATE_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

  state_t               state, state_next;
  logic [CHAIN_LEN-1:0] chain, chain_next;
  logic [7:0]           upd_cnt;
  logic [15:0]          lock_cnt;
  logic                 lock_flag;
  logic                 prev_scanclk, prev_cfgupd;
  logic                 shift_ev, cu_edge, enter_update;

  // scanclk is treated as data: a single register gives the edge, no synchroniser.
  assign shift_ev = scanclk && !prev_scanclk && scanclkena && (state != UPDATE);
  assign cu_edge  = configupdate && !prev_cfgupd;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_next   = state;
    chain_next   = shift_ev ? {chain[CHAIN_LEN-2:0], scandata} : chain;
    if (areset) begin
      state_next = RELOCK;
    end else begin
      case (state)
        RELOCK: if (lock_cnt == LOCK_LAST) state_next = IDLE;
        IDLE: begin
          if (cu_edge)       state_next = UPDATE;
          else if (shift_ev) state_next = SHIFT;
        end
        SHIFT:  if (cu_edge) state_next = UPDATE;
        UPDATE: if (upd_cnt == UPD_LAST) state_next = RELOCK;
        default: state_next = RELOCK;
      endcase
    end
    enter_update = (state_next == UPDATE) && (state != UPDATE);
  end

  // NOTE: the wide chain/active_cfg registers are plain flops, not RAM, so resetting
  // them to INIT_CFG is legal and required to discard partial images.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RELOCK;
      chain        <= INIT_CFG;
      active_cfg   <= INIT_CFG;
      shift_count  <= '0;
      upd_cnt      <= '0;
      lock_cnt     <= '0;
      lock_flag    <= 1'b0;
      prev_scanclk <= 1'b0;
      prev_cfgupd  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      prev_scanclk <= scanclk;
      prev_cfgupd  <= configupdate;
      state        <= state_next;
      chain        <= chain_next;

      // The update captures the post-shift image when a shift lands in the same cycle.
      if (enter_update) begin
        active_cfg  <= chain_next;
        shift_count <= '0;
      end else if (shift_ev && shift_count != 8'hFF) begin
        shift_count <= shift_count + 8'd1;
      end

      upd_cnt  <= (state == UPDATE && state_next == UPDATE) ? upd_cnt + 8'd1 : '0;
      lock_cnt <= (state == RELOCK && state_next == RELOCK && !areset) ? lock_cnt + 16'd1 : '0;

      if (areset || enter_update)
        lock_flag <= 1'b0;
      else if (state == RELOCK && state_next == IDLE)
        lock_flag <= 1'b1;
    end
  end

  assign scandataout = chain[CHAIN_LEN-1];
  assign scandone    = (state == IDLE) && lock_flag;
  assign locked      = (state == IDLE || state == SHIFT) && lock_flag && pfdena;

endmodule

// File: tb/tb_pll_scan_responder.sv
// Directed bench for pll_scan_responder: lock-up, shifting, updates, areset,
// pfdena gating and asynchronous reset mid-shift.
module tb_pll_scan_responder;

  logic         clock = 1'b0;
  logic         reset, areset, pfdena, scanclk, scanclkena, scandata, configupdate;
  logic         scandataout, scandone, locked;
  logic [143:0] active_cfg;
  logic [7:0]   shift_count;

  int compared   = 0;
  int mismatched = 0;

  pll_scan_responder #(
    .CHAIN_LEN(144), .INIT_CFG(144'd0), .UPDATE_CYCLES(4), .LOCK_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .areset(areset), .pfdena(pfdena),
    .scanclk(scanclk), .scanclkena(scanclkena), .scandata(scandata),
    .configupdate(configupdate), .scandataout(scandataout), .scandone(scandone),
    .locked(locked), .active_cfg(active_cfg), .shift_count(shift_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic shift_bit(input logic b);
    scandata   = b;
    scanclkena = 1'b1;
    scanclk    = 1'b1;
    tick();
    scanclk    = 1'b0;
    tick();
  endtask

  logic [143:0] pat_img;
  logic [143:0] ones_img;
  logic [143:0] exp_img;
  logic [7:0]   pat;
  logic [7:0]   tail;

  initial begin
    reset = 1'b1; areset = 1'b0; pfdena = 1'b1; scanclk = 1'b0;
    scanclkena = 1'b0; scandata = 1'b0; configupdate = 1'b0;
    pat      = 8'hA5;
    tail     = 8'h3C;
    pat_img  = {18{8'hA5}};
    ones_img = '1;

    // Reset state and first lock.
    tick(); tick();
    check("rst_locked", locked, 1'b0);
    check("rst_scandone", scandone, 1'b0);
    check("rst_active_cfg", active_cfg, 144'd0);
    check("rst_shift_count", shift_count, 8'd0);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("lock0_locked_c%0d", i), locked, (i == 16));
      check($sformatf("lock0_done_c%0d", i), scandone, (i == 16));
    end

    // 150 ones from a zero chain: MSB appears exactly on shift 144.
    for (int k = 1; k <= 150; k++) begin
      shift_bit(1'b1);
      check($sformatf("sdo_shift%0d", k), scandataout, (k >= 144));
      if (k == 1) check("done_low_in_shift", scandone, 1'b0);
    end
    check("count_150", shift_count, 8'd150);
    // scanclk edges without scanclkena must not shift.
    scanclkena = 1'b0;
    scandata   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      scanclk = 1'b1; tick(); scanclk = 1'b0; tick();
    end
    check("noena_count", shift_count, 8'd150);
    check("noena_sdo", scandataout, 1'b1);
    for (int k = 0; k < 110; k++) shift_bit(1'b1);
    check("count_saturate", shift_count, 8'd255);

    // Apply the all-ones image.
    configupdate = 1'b1; tick(); configupdate = 1'b0;
    check("upd1_active_cfg", active_cfg, ones_img);
    check("upd1_count_zero", shift_count, 8'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("upd1_locked_c%0d", i), locked, (i == 20));
    end

    // 0xA5 pattern, MSB first, then a configupdate pulse.
    for (int i = 0; i < 144; i++) begin
      shift_bit(pat[7 - (i % 8)]);
      if (i == 0) check("pat_done_low", scandone, 1'b0);
    end
    check("pat_count_144", shift_count, 8'd144);
    check("pat_done_still_low", scandone, 1'b0);
    configupdate = 1'b1; tick(); configupdate = 1'b0;
    check("pat_active_cfg", active_cfg, pat_img);
    check("pat_locked_entry", locked, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("pat_locked_c%0d", i), locked, (i == 20));
    end
    check("pat_done_after", scandone, 1'b1);
    check("pat_count_after", shift_count, 8'd0);

    // Final shift and configupdate edge in the same clock; extra edges are ignored.
    for (int i = 0; i < 7; i++) shift_bit(tail[7 - i]);
    check("same_count_7", shift_count, 8'd7);
    scandata = tail[0]; scanclkena = 1'b1; scanclk = 1'b1; configupdate = 1'b1;
    tick();
    scanclk = 1'b0; configupdate = 1'b0;
    exp_img = {pat_img[135:0], 8'h3C};
    check("same_active_cfg", active_cfg, exp_img);
    check("same_count_zero", shift_count, 8'd0);
    for (int i = 1; i <= 20; i++) begin
      configupdate = (i == 3 || i == 12);
      tick();
      check($sformatf("same_locked_c%0d", i), locked, (i == 20));
    end
    configupdate = 1'b0;
    tick();
    check("same_active_kept", active_cfg, exp_img);
    check("same_locked_kept", locked, 1'b1);

    // areset in IDLE with a simultaneous configupdate edge and shift event.
    areset = 1'b1; configupdate = 1'b1; scanclk = 1'b1; scanclkena = 1'b1; scandata = 1'b1;
    tick();
    configupdate = 1'b0; scanclk = 1'b0;
    check("areset_locked", locked, 1'b0);
    check("areset_active_cfg", active_cfg, exp_img);
    check("areset_shift_applied", shift_count, 8'd1);
    for (int i = 0; i < 9; i++) tick();
    areset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("areset_locked_c%0d", i), locked, (i == 16));
    end
    check("areset_active_after", active_cfg, exp_img);

    // pfdena low gates locked without leaving IDLE.
    pfdena = 1'b0; #1;
    check("pfd_locked", locked, 1'b0);
    tick();
    check("pfd_idle", scandone, 1'b1);
    pfdena = 1'b1; #1;
    check("pfd_relocked", locked, 1'b1);

    // Asynchronous reset after 70 bits of a shift.
    tick();
    for (int i = 0; i < 70; i++) shift_bit(1'b1);
    check("mid_count_71", shift_count, 8'd71);
    scanclk = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async_active_cfg", active_cfg, 144'd0);
    check("async_count", shift_count, 8'd0);
    check("async_sdo", scandataout, 1'b0);
    check("async_locked", locked, 1'b0);
    check("async_done", scandone, 1'b0);
    scanclk = 1'b0; scanclkena = 1'b0; scandata = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("rec_locked_c%0d", i), locked, (i == 16));
    end
    check("rec_active_cfg", active_cfg, 144'd0);
    check("rec_count", shift_count, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
